uart_rx_decoder: RTL and testbench

UART_RX_DECODER -- requirements
Module: uart_rx_decoder

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx_decoder.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive path: frame shape and the
// receiver state encoding.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Counter width able to hold the value n (n >= 1).
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings the asynchronous serial line into the
// clk domain. Both flops reset to RESET_VAL so an idle-high line does not
// produce a spurious edge out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops; only sync_q is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make both flops sample their inputs
      // from before the edge; blocking here would collapse the chain to one.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_decoder.sv
// 8N1 UART receiver. Detects the start edge on the synchronized line,
// samples each bit at its centre with a counter that reloads on every
// sample, and reports either a good byte (rx_valid) or a framing error
// (rx_frame_err) as one-cycle strobes.
module uart_rx_decoder
  import uart_pkg::*;
#(
  parameter int uart_baudrate_period_ns = 8680,
  parameter int clk_period_ns           = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       busy
);

  localparam int BIT_CYCLES  = uart_baudrate_period_ns / clk_period_ns;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = count_width(BIT_CYCLES);
  localparam int IDX_W       = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(BIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  if (BIT_CYCLES < 4) begin : g_bad_baud
    $error("uart_rx_decoder: BIT_CYCLES must be at least 4");
  end
  if (STOP_BITS != 1) begin : g_bad_stop
    $error("uart_rx_decoder: only one stop bit is supported");
  end

  logic s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (uart_tx),
    .q_o (s)
  );

  rx_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         shift_q;
  logic               s_prev_q;
  logic [1:0]         warm_q;
  logic [7:0]         rx_data_q;
  logic               rx_valid_q;
  logic               rx_frame_err_q;
  logic               busy_q;

  logic armed;
  logic fall_edge;
  logic sample_now;

  // Edge and sample-point qualifiers derived from the current registers.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no
    // latch can be inferred.
    armed      = 1'b0;
    fall_edge  = 1'b0;
    sample_now = 1'b0;
    // The synchronizer's reset value is still in s_prev_q for the first
    // three cycles after reset; only once it holds a real line sample can a
    // high-to-low transition be trusted (a line stuck low must not start).
    armed      = (warm_q == 2'd3);
    fall_edge  = armed && s_prev_q && !s;
    sample_now = (cnt_q == CNT_ONE);
  end

  // Receiver FSM with registered outputs; the counter reloads on each
  // sample so bit-centre timing never accumulates error across the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      shift_q        <= '0;
      s_prev_q       <= 1'b1;
      warm_q         <= '0;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      s_prev_q       <= s;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      if (!armed) begin
        warm_q <= warm_q + 2'd1;
      end

      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (fall_edge) begin
            state_q <= START;
            cnt_q   <= CNT_HALF;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (sample_now) begin
            if (!s) begin
              state_q <= DATA;
              idx_q   <= '0;
              cnt_q   <= CNT_BIT;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              state_q <= IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        DATA: begin
          if (sample_now) begin
            shift_q[idx_q] <= s;
            cnt_q          <= CNT_BIT;
            if (idx_q == IDX_LAST) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        STOP: begin
          if (sample_now) begin
            cnt_q <= '0;
            if (s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
            end else begin
              rx_frame_err_q <= 1'b1;
              state_q        <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        WAIT_HIGH: begin
          // A break holds the line low; stay quiet until it is released.
          if (s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_ECHO
  // Simulation-only console echo of each received character.
  always @(posedge clk) begin
    if (rx_valid_q) begin
      $write("%c", rx_data_q);
    end
  end
`endif

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Bench for uart_rx_decoder. Two instances run in parallel: A at the
// default 868-cycle bit, B at 434 cycles. Every frame the bench sends
// pushes the outcome it must produce (byte or framing error) and the
// cycle it must appear on; one monitor compares every strobe against that.
module tb_uart_rx_decoder;

  localparam int BIT_A  = 868;
  localparam int HALF_A = 434;
  localparam int BIT_B  = 434;
  localparam int HALF_B = 217;
  localparam int DETECT = 3;    // line change at a negedge -> start seen 3 posedges later
  localparam int FERR   = 256;  // event code for a framing error

  typedef struct {
    int code;
    int due;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       line_a, line_b;
  logic [7:0] data_a, data_b;
  logic       val_a, val_b, err_a, err_b, busy_a, busy_b;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  int  last_strobe_a = 0;
  logic prev_val_a = 1'b0, prev_val_b = 1'b0;
  logic prev_err_a = 1'b0, prev_err_b = 1'b0;
  ev_t q_a[$];
  ev_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_decoder #(.uart_baudrate_period_ns(8680), .clk_period_ns(10)) dut_a (
    .clk(clk), .rst(rst_a), .uart_tx(line_a), .rx_data(data_a),
    .rx_valid(val_a), .rx_frame_err(err_a), .busy(busy_a)
  );

  uart_rx_decoder #(.uart_baudrate_period_ns(4340), .clk_period_ns(10)) dut_b (
    .clk(clk), .rst(rst_b), .uart_tx(line_b), .rx_data(data_b),
    .rx_valid(val_b), .rx_frame_err(err_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare one observed strobe with the oldest outstanding expectation.
  task automatic check_strobe(input int k, input logic e, input logic [7:0] d);
    string pfx = (k == 0) ? "a" : "b";
    int    sz  = (k == 0) ? q_a.size() : q_b.size();
    ev_t   ev;
    check({pfx, "_strobe_expected"}, 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      if (k == 0) ev = q_a.pop_front();
      else        ev = q_b.pop_front();
      check({pfx, "_strobe_kind_is_err"}, 32'(e), 32'(ev.code == FERR));
      if (ev.code != FERR) check({pfx, "_strobe_data"}, 32'(d), ev.code);
      check({pfx, "_strobe_cycle"}, cyc, ev.due);
    end
  endtask

  // Per-cycle output checks for both instances.
  always @(negedge clk) begin
    if (mon_en) begin
      check("a_valid_err_exclusive", 32'(val_a & err_a), 32'd0);
      check("b_valid_err_exclusive", 32'(val_b & err_b), 32'd0);
      check("a_strobe_single_cycle", 32'((prev_val_a & val_a) | (prev_err_a & err_a)), 32'd0);
      check("b_strobe_single_cycle", 32'((prev_val_b & val_b) | (prev_err_b & err_b)), 32'd0);
      if (val_a || err_a) begin
        check_strobe(0, err_a, data_a);
        last_strobe_a <= cyc;
      end
      if (val_b || err_b) check_strobe(1, err_b, data_b);
    end
    prev_val_a <= val_a;
    prev_val_b <= val_b;
    prev_err_a <= err_a;
    prev_err_b <= err_b;
  end

  task automatic drive(input int k, input logic v);
    if (k == 0) line_a = v;
    else        line_b = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send one 8N1 frame with the given bit length; stop_hi=0 forces a bad stop.
  task automatic send(input int k, input logic [7:0] d, input int bitc, input bit stop_hi);
    ev_t ev;
    ev.code = stop_hi ? int'(d) : FERR;
    ev.due  = cyc + DETECT + ((k == 0) ? (HALF_A + 9 * BIT_A) : (HALF_B + 9 * BIT_B));
    if (k == 0) q_a.push_back(ev);
    else        q_b.push_back(ev);
    drive(k, 1'b0);
    wait_cycles(bitc);
    for (int i = 0; i < 8; i++) begin
      drive(k, d[i]);
      wait_cycles(bitc);
    end
    drive(k, stop_hi);
    wait_cycles(bitc);
  endtask

  task automatic run_a();
    int p;
    // Single byte at nominal baud, with the exact strobe cycle pinned.
    p = cyc;
    send(0, 8'h41, BIT_A, 1'b1);
    check("a_0x41_latency", last_strobe_a - p, 32'd8249);
    check("a_0x41_data", 32'(data_a), 32'h41);
    wait_cycles(50);

    // Back-to-back frames with no idle gap.
    send(0, 8'h00, BIT_A, 1'b1);
    send(0, 8'hFF, BIT_A, 1'b1);
    check("a_b2b_last_data", 32'(data_a), 32'hFF);
    check("a_b2b_drained", q_a.size(), 32'd0);
    wait_cycles(50);

    // 100-cycle glitch: no strobe, busy drops once the start check fails.
    p = cyc;
    drive(0, 1'b0);
    wait_cycles(50);
    check("a_glitch_busy_high", 32'(busy_a), 32'd1);
    wait_cycles(50);
    drive(0, 1'b1);
    wait_cycles(p + DETECT + 435 - cyc);
    check("a_glitch_busy_low", 32'(busy_a), 32'd0);
    wait_cycles(100);

    // Bad stop bit followed by a long break.
    send(0, 8'h55, BIT_A, 1'b0);
    wait_cycles(20 * BIT_A);
    check("a_break_busy_high", 32'(busy_a), 32'd1);
    check("a_break_data_kept", 32'(data_a), 32'hFF);
    drive(0, 1'b1);
    wait_cycles(6);
    check("a_break_busy_released", 32'(busy_a), 32'd0);
  endtask

  task automatic run_b();
    logic [7:0] a5 = 8'hA5;
    logic [7:0] msg [6];
    msg[0] = 8'h48; msg[1] = 8'h65; msg[2] = 8'h6C;
    msg[3] = 8'h6C; msg[4] = 8'h6F; msg[5] = 8'h0A;
    wait_cycles(20);

    // Start 0xA5, reset during data bit 3 (line low), hold low afterwards.
    drive(1, 1'b0);
    wait_cycles(BIT_B);
    for (int i = 0; i < 4; i++) begin
      drive(1, a5[i]);
      if (i < 3) wait_cycles(BIT_B);
    end
    wait_cycles(200);
    rst_b = 1'b1;
    wait_cycles(1);
    check("b_rst_busy", 32'(busy_b), 32'd0);
    check("b_rst_data", 32'(data_b), 32'h00);
    wait_cycles(2);
    rst_b = 1'b0;
    wait_cycles(2 * BIT_B);
    check("b_low_after_rst_no_start", 32'(busy_b), 32'd0);
    drive(1, 1'b1);
    wait_cycles(2 * BIT_B);
    send(1, 8'h0A, BIT_B, 1'b1);
    check("b_after_rst_data", 32'(data_b), 32'h0A);
    wait_cycles(100);

    // "Hello\n": first half 2% slow, second half 2% fast, no gaps.
    for (int i = 0; i < 6; i++) begin
      send(1, msg[i], (i < 3) ? 443 : 425, 1'b1);
    end
    check("b_hello_last_data", 32'(data_b), 32'h0A);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    line_a = 1'b1;
    line_b = 1'b1;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    wait_cycles(3);
    check("a_reset_data", 32'(data_a), 32'h00);
    check("a_reset_valid", 32'(val_a), 32'd0);
    check("a_reset_err", 32'(err_a), 32'd0);
    check("a_reset_busy", 32'(busy_a), 32'd0);
    check("b_reset_data", 32'(data_b), 32'h00);
    check("b_reset_valid", 32'(val_b), 32'd0);
    check("b_reset_err", 32'(err_b), 32'd0);
    check("b_reset_busy", 32'(busy_b), 32'd0);
    mon_en = 1'b1;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    wait_cycles(10);
    fork
      run_a();
      run_b();
    join
    wait_cycles(10);
    check("a_all_strobes_seen", q_a.size(), 32'd0);
    check("b_all_strobes_seen", q_b.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
